// File: rtl/tb_memory_multichannel.sv
// Multi-channel simulation memory. Each channel has a private bank, a fixed
// response latency, a bounded in-order response FIFO and out-of-range errors.

module tb_memory_channel #(
  parameter int AddrWidth      = 48,
  parameter int DataWidth      = 64,
  parameter int MemWords       = 1024,
  parameter int Latency        = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AddrWidth-1:0]   req_addr,
  input  logic                   req_we,
  input  logic [DataWidth-1:0]   req_wdata,
  input  logic [DataWidth/8-1:0] req_strb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DataWidth-1:0]   rsp_rdata,
  output logic                   rsp_err
);
  localparam int NB   = DataWidth / 8;
  localparam int OFFS = $clog2(NB);
  localparam int IDXW = $clog2(MemWords);
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int CdW  = (Latency > 1) ? $clog2(Latency) : 1;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
    logic [CdW-1:0]       cd;
  } ent_t;

  // Bank starts zeroed and is deliberately outside the reset domain.
  logic [DataWidth-1:0] mem [MemWords] = '{default: '0};

  ent_t            fifo_q [MaxOutstanding];
  ent_t            fifo_d [MaxOutstanding];
  ent_t            new_ent;
  logic [CntW-1:0] count_q, count_d, wpos;
  logic [IDXW-1:0] idx;
  logic            in_range, acc, pop;

  assign in_range  = (req_addr >> (OFFS + IDXW)) == '0;
  assign idx       = req_addr[OFFS +: IDXW];
  assign req_ready = count_q < CntW'(MaxOutstanding);
  assign acc       = req_valid & req_ready;
  assign rsp_valid = (count_q != '0) && (fifo_q[0].cd == '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_q[0].rdata : '0;
  assign rsp_err   = rsp_valid & fifo_q[0].err;
  assign wpos      = count_q - CntW'(pop);
  assign count_d   = count_q + CntW'(acc) - CntW'(pop);

  // Read data is captured at accept time, before this edge's write lands.
  always_comb begin
    new_ent       = '0;
    new_ent.rdata = (in_range && !req_we) ? mem[idx] : '0;
    new_ent.err   = ~in_range;
    new_ent.cd    = CdW'(Latency - 1);
  end

  // Byte-masked bank write for accepted in-range writes.
  always_ff @(posedge clk_i) begin
    if (acc && req_we && in_range) begin
      for (int b = 0; b < NB; b++)
        if (req_strb[b]) mem[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
    end
  end

  // Shift-style FIFO: head at index 0; countdowns age, pop shifts, push fills tail.
  always_comb begin
    for (int i = 0; i < MaxOutstanding; i++) begin
      fifo_d[i] = fifo_q[i];
      if (fifo_q[i].cd != '0) fifo_d[i].cd = fifo_q[i].cd - CdW'(1);
    end
    if (pop) begin
      for (int i = 0; i < MaxOutstanding - 1; i++) fifo_d[i] = fifo_d[i+1];
      fifo_d[MaxOutstanding-1] = '0;
    end
    for (int i = 0; i < MaxOutstanding; i++)
      if (acc && wpos == CntW'(i)) fifo_d[i] = new_ent;
  end

  // FIFO state register; reset drops all in-flight responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= fifo_d[i];
    end
  end
endmodule

module tb_memory_multichannel #(
  parameter int NumChannels    = 8,
  parameter int AddrWidth      = 48,
  parameter int DataWidth      = 64,
  parameter int MemWords       = 1024,
  parameter int Latency        = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumChannels-1:0]             req_valid_i,
  output logic [NumChannels-1:0]             req_ready_o,
  input  logic [NumChannels*AddrWidth-1:0]   req_addr_i,
  input  logic [NumChannels-1:0]             req_we_i,
  input  logic [NumChannels*DataWidth-1:0]   req_wdata_i,
  input  logic [NumChannels*DataWidth/8-1:0] req_strb_i,
  output logic [NumChannels-1:0]             rsp_valid_o,
  input  logic [NumChannels-1:0]             rsp_ready_i,
  output logic [NumChannels*DataWidth-1:0]   rsp_rdata_o,
  output logic [NumChannels-1:0]             rsp_err_o
);
  localparam int NB = DataWidth / 8;

  // One fully independent channel per slice; no cross-channel interaction.
  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    tb_memory_channel #(
      .AddrWidth(AddrWidth), .DataWidth(DataWidth), .MemWords(MemWords),
      .Latency(Latency), .MaxOutstanding(MaxOutstanding)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_valid(req_valid_i[c]),
      .req_ready(req_ready_o[c]),
      .req_addr (req_addr_i[c*AddrWidth +: AddrWidth]),
      .req_we   (req_we_i[c]),
      .req_wdata(req_wdata_i[c*DataWidth +: DataWidth]),
      .req_strb (req_strb_i[c*NB +: NB]),
      .rsp_valid(rsp_valid_o[c]),
      .rsp_ready(rsp_ready_i[c]),
      .rsp_rdata(rsp_rdata_o[c*DataWidth +: DataWidth]),
      .rsp_err  (rsp_err_o[c])
    );
  end
endmodule

// File: tb/tb_tb_memory_multichannel.sv
// Scoreboarded bench: expectations come from a bench-side memory model and are
// queued per channel at issue time, then popped when a response handshakes.

module tb_tb_memory_multichannel;
  localparam int NC = 8;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int NW = 1024;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic                  clk = 0;
  logic                  rst;
  logic [NC-1:0]         req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [NC*AW-1:0]      req_addr;
  logic [NC*DW-1:0]      req_wdata, rsp_rdata;
  logic [NC*DW/8-1:0]    req_strb;

  int   checks = 0;
  int   errors = 0;
  rsp_t sb [NC][$];
  logic [DW-1:0] model [NC][NW];

  tb_memory_multichannel dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  // Response monitor: every handshake pops and compares the channel's scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int c = 0; c < NC; c++) begin
        if (rsp_valid[c] && rsp_ready[c]) begin
          checks++;
          if (sb[c].size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected_ch%0d: got rdata %h err %b, expected no response",
                     c, rsp_rdata[c*DW +: DW], rsp_err[c]);
          end else begin
            rsp_t e;
            e = sb[c].pop_front();
            if ({rsp_err[c], rsp_rdata[c*DW +: DW]} !== {e.err, e.rdata}) begin
              errors++;
              $display("FAIL rsp_data_ch%0d: got rdata %h err %b, expected rdata %h err %b",
                       c, rsp_rdata[c*DW +: DW], rsp_err[c], e.rdata, e.err);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  // Drives one request for the coming edge and records its expected response.
  task automatic issue(input int c, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW/8-1:0] st);
    rsp_t e;
    bit   inr;
    int   idx;
    inr = (a[AW-1:13] == '0);
    idx = int'(a[12:3]);
    e.err   = !inr;
    e.rdata = (!we && inr) ? model[c][idx] : '0;
    if (we && inr)
      for (int b = 0; b < DW/8; b++)
        if (st[b]) model[c][idx][b*8 +: 8] = wd[b*8 +: 8];
    sb[c].push_back(e);
    req_valid[c]           = 1'b1;
    req_we[c]              = we;
    req_addr[c*AW +: AW]   = a;
    req_wdata[c*DW +: DW]  = wd;
    req_strb[c*8 +: 8]     = st;
  endtask

  task automatic wait_drain(input int c, input int budget);
    int n = 0;
    while (sb[c].size() != 0 && n < budget) begin tick(); n++; end
    checks++;
    if (sb[c].size() != 0) begin
      errors++;
      $display("FAIL drain_ch%0d: %0d responses outstanding, expected 0", c, sb[c].size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (req_ready !== 8'hFF) begin errors++; $display("FAIL reset_ready: got %h expected ff", req_ready); end
    if (rsp_valid !== 8'h00) begin errors++; $display("FAIL reset_valid: got %h expected 00", rsp_valid); end
    if (rsp_rdata !== '0)    begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
    if (rsp_err !== 8'h00)   begin errors++; $display("FAIL reset_err: got %h expected 00", rsp_err); end
  endtask

  task automatic test_write_read();
    tick();
    issue(0, 1'b1, 48'h10, 64'h1122334455667788, 8'hFF);      // cycle t
    @(negedge clk);
    checks++;
    if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL wr_lat_t: got valid %b expected 0", rsp_valid[0]); end
    tick();
    issue(0, 1'b0, 48'h10, '0, '0);                            // cycle t+1
    @(negedge clk);
    checks++;
    if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL wr_lat_t1: got valid %b expected 0", rsp_valid[0]); end
    tick();                                                    // cycle t+2
    @(negedge clk);
    checks++;
    if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL wr_rsp_t2: got valid %b expected 1", rsp_valid[0]); end
    tick();                                                    // cycle t+3
    @(negedge clk);
    checks++;
    if ({rsp_valid[0], rsp_rdata[63:0]} !== {1'b1, 64'h1122334455667788}) begin
      errors++;
      $display("FAIL rd_rsp_t3: got valid %b rdata %h expected 1 1122334455667788", rsp_valid[0], rsp_rdata[63:0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL rd_idle_t4: got valid %b expected 0", rsp_valid[0]); end
    wait_drain(0, 10);
  endtask

  task automatic test_partial_strobe();
    tick();
    issue(0, 1'b1, 48'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F); tick();
    issue(0, 1'b0, 48'h10, '0, '0);
    @(negedge clk);
    tick(); tick();
    @(negedge clk);
    checks++;
    if (rsp_rdata[63:0] !== 64'h11223344AAAAAAAA) begin
      errors++;
      $display("FAIL strobe_merge: got %h expected 11223344aaaaaaaa", rsp_rdata[63:0]);
    end
    wait_drain(0, 10);
  endtask

  task automatic test_out_of_range();
    tick();
    issue(1, 1'b1, 48'h0,    64'hCAFEF00D12345678, 8'hFF); tick();
    issue(1, 1'b0, 48'h2000, '0, '0);                       tick();
    issue(1, 1'b1, 48'h2000, 64'hFFFFFFFFFFFFFFFF, 8'hFF); tick();
    issue(1, 1'b0, 48'h0,    '0, '0);                       tick();
    issue(1, 1'b0, {1'b1, 47'h0}, '0, '0);                  tick();
    wait_drain(1, 20);
  endtask

  task automatic test_backpressure_full();
    tick();
    for (int i = 0; i < 4; i++) begin
      issue(2, 1'b1, AW'(i*8), {$urandom, $urandom}, 8'hFF); tick();
    end
    wait_drain(2, 20);
    rsp_ready[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(2, 1'b0, AW'(i*8), '0, '0);
      @(negedge clk);
      checks++;
      if (req_ready[2] !== 1'b1) begin errors++; $display("FAIL full_rdy_%0d: got %b expected 1", i, req_ready[2]); end
      tick();
    end
    @(negedge clk);
    checks++;
    if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL full_rdy_drop: got %b expected 0", req_ready[2]); end
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({rsp_valid[2], req_ready[2], rsp_rdata[2*DW +: DW]} !== {1'b1, 1'b0, sb[2][0].rdata}) begin
        errors++;
        $display("FAIL full_hold_%0d: got valid %b ready %b rdata %h expected 1 0 %h",
                 k, rsp_valid[2], req_ready[2], rsp_rdata[2*DW +: DW], sb[2][0].rdata);
      end
    end
    tick();
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready[2] !== 1'b0) begin errors++; $display("FAIL full_rdy_pop_cycle: got %b expected 0", req_ready[2]); end
    tick();
    rsp_ready[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready[2] !== 1'b1) begin errors++; $display("FAIL full_rdy_after_pop: got %b expected 1", req_ready[2]); end
    tick();
    rsp_ready[2] = 1'b1;
    wait_drain(2, 20);
  endtask

  task automatic test_independence();
    tick();
    for (int i = 0; i < 16; i++) begin
      issue(3, 1'($urandom), AW'($urandom_range(0, 7) * 8), {$urandom, $urandom}, 8'($urandom));
      issue(5, 1'($urandom), AW'($urandom_range(0, 7) * 8), {$urandom, $urandom}, 8'($urandom));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      issue(3, 1'b0, AW'(i*8), '0, '0);
      issue(5, 1'b0, AW'(i*8), '0, '0);
      tick();
    end
    wait_drain(3, 20);
    wait_drain(5, 20);
  endtask

  task automatic test_reset_midflight();
    tick();
    issue(4, 1'b1, 48'h38, 64'hDEADBEEF0BADF00D, 8'hFF); tick();
    wait_drain(4, 20);
    rsp_ready[4] = 1'b0;
    issue(4, 1'b0, 48'h38, '0, '0); tick();
    issue(4, 1'b0, 48'h38, '0, '0); tick();
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid[4] !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b expected 1", rsp_valid[4]); end
    tick();
    rst = 1'b1;
    sb[4].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (rsp_valid !== 8'h00) begin errors++; $display("FAIL mid_rst_valid: got %h expected 00", rsp_valid); end
    if (req_ready !== 8'hFF) begin errors++; $display("FAIL mid_rst_ready: got %h expected ff", req_ready); end
    rsp_ready = '1;
    tick();
    issue(4, 1'b0, 48'h38, '0, '0); tick();
    issue(3, 1'b0, 48'h0, '0, '0);  tick();
    wait_drain(4, 20);
    wait_drain(3, 20);
  endtask

  initial begin
    for (int c = 0; c < NC; c++)
      for (int w = 0; w < NW; w++) model[c][w] = '0;
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0;
    req_wdata = '0; req_strb = '0; rsp_ready = '1;
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_out_of_range();
    test_backpressure_full();
    test_independence();
    test_reset_midflight();
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (sb[c].size() != 0) begin
        errors++;
        $display("FAIL final_empty_ch%0d: %0d left, expected 0", c, sb[c].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tb_memory_multichannel.md
Name: tb_memory_multichannel

Overview:
Parametrised multi-channel test memory model for simulation harnesses. It replaces one-instance-per-channel memories (for example eight HBM channels) with a single block of NumChannels independent channels. Each channel has a private bank, a fixed configurable response latency, bounded outstanding requests, in-order responses with backpressure, and out-of-range error signalling. Simple valid/ready request/response ports sit between the harness and DUT-side protocol adapters.

Parameters:
NumChannels, 8, number of independent channels and banks
AddrWidth, 48, request byte-address width
DataWidth, 64, data width in bits; power of two, >= 8
MemWords, 1024, words per channel bank; power of two
Latency, 2, cycles from request accept to earliest response valid; >= 1
MaxOutstanding, 4, accepted-but-unpopped responses per channel; >= 1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  NumChannels  request valid, one bit per channel
req_ready_o  out  NumChannels  request ready, one bit per channel
req_addr_i  in  NumChannels*AddrWidth  byte address; channel c at slice [c*AddrWidth +: AddrWidth]
req_we_i  in  NumChannels  1 = write, 0 = read
req_wdata_i  in  NumChannels*DataWidth  write data
req_strb_i  in  NumChannels*DataWidth/8  byte write enables
rsp_valid_o  out  NumChannels  response valid
rsp_ready_i  in  NumChannels  response ready
rsp_rdata_o  out  NumChannels*DataWidth  read data; 0 for writes and errors
rsp_err_o  out  NumChannels  1 = address out of range

Behaviour:
- Reset: rst_i sampled on the rising edge of clk_i; synchronous active-high. Clears all response FIFOs and counters. After reset: req_ready_o = all ones, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
- Bank contents are zero at time 0 and are NOT affected by rst_i. Reset mid-operation drops every in-flight response; writes accepted before the reset edge persist.
- Channels are fully independent; there is no cross-channel arbitration or ordering.
- Address decode: OFFS = log2(DataWidth/8), IDXW = log2(MemWords). Word index = addr[OFFS +: IDXW]. The address is in range iff addr[AddrWidth-1 : OFFS+IDXW] == 0. Low OFFS bits are ignored.
- Accept: a request is accepted when req_valid_i & req_ready_o in a cycle.
  - On accept of an in-range write, bytes with strb = 1 are updated at that clock edge.
  - On accept of an in-range read, bank data is sampled in the same cycle, so a write accepted in an earlier cycle is visible.
  - On accept of an out-of-range request, no write is performed; the response has err = 1 and rdata = 0.
- Per-channel response FIFO, depth MaxOutstanding. Each entry holds {rdata, err, countdown}.
  - On accept, an entry is pushed with countdown = Latency-1.
  - Every cycle, each entry's countdown decrements, saturating at 0.
- Response output:
  - rsp_valid_o[c] = FIFO non-empty and head countdown == 0.
  - Pop on rsp_valid & rsp_ready.
  - Data and err are stable while valid is held low-ready.
  - Responses are returned in accept order.
- Latency: a request accepted in cycle t has its response valid no earlier than t+Latency. It is valid exactly at t+Latency if the FIFO ahead has drained.
- req_ready_o[c] = (count < MaxOutstanding). Count is the registered FIFO occupancy. Ready has no combinational path from rsp_ready_i or req_valid_i.
- Full FIFO:
  - A simultaneous pop in the same cycle does not raise ready until the next cycle.
  - Simultaneous push and pop on a non-full FIFO keeps count unchanged.
- Count width is log2(MaxOutstanding+1). There is no overflow: push only happens when count < MaxOutstanding.

Test Plan:
- Reset/idle: hold rst_i = 1 for 3 cycles, then release -> req_ready_o = 8'hFF, rsp_valid_o = 0 on all channels.
- Write then read, Latency = 2, DataWidth = 64, channel 0:
  - write addr 0x10, data 0x1122334455667788, strb 0xFF at cycle t -> rsp_valid at t+2, err = 0, rdata = 0.
  - read addr 0x10 at t+1 -> rsp_valid at t+3, rdata = 0x1122334455667788.
- Partial strobe: write 0xAAAA... with strb 0x0F to a word holding 0x1122334455667788, then read -> 0x11223344AAAAAAAA.
- Out of range: read addr 0x2000 with MemWords = 1024, DataWidth = 64 -> err = 1, rdata = 0. A write to the same address leaves the bank unchanged.
- Backpressure and full, MaxOutstanding = 4, rsp_ready = 0:
  - issue 4 reads -> ready drops to 0 after the 4th accept.
  - hold 10 cycles -> rsp_valid stays 1 with head data stable.
  - assert rsp_ready for 1 cycle -> ready = 1 on the next cycle; responses return in order.
- Channel independence and reset mid-flight:
  - concurrent traffic on channels 3 and 5 -> no interference.
  - assert rst_i with 2 responses pending -> rsp_valid = 0 the next cycle, and a prior write is still readable.
